fifo_port_controller: RTL and testbench
=======================================

# fifo_port_controller

Controller that shares one synchronous FIFO (8-bit, standard-mode read, 1-cycle read latency, full/empty flags) between several write requesters and presents the FIFO read port as a valid/ready stream. Writes are granted round-robin with an optional burst hold. Reads are prefetched into a 2-entry output buffer so the consumer sees registered, back-pressurable data at full throughput. It sits directly between the FIFO instance and the producer/consumer logic.

## Interface
- NUM_REQ, 4, number of write requesters (2–8)
- DATA_W, 8, data width; must match the FIFO width
- MAX_BURST, 4, max consecutive accepted beats a granted requester keeps the grant (1 = pure round-robin)
- clk  in  1  system clock; all logic on its rising edge
- srst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write valid
- req_data  in  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- grant_id  out  clog2(NUM_REQ)  index of the current grant (valid when fifo_wr_en=1)
- fifo_din  out  DATA_W  to FIFO din
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- fifo_rd_en  out  1  to FIFO rd_en
- fifo_dout  in  DATA_W  from FIFO dout; valid the cycle after fifo_rd_en
- fifo_empty  in  1  from FIFO empty
- out_valid  out  1  read-stream valid
- out_data  out  DATA_W  read-stream data
- out_ready  in  1  read-stream ready

## Operation
- Write arbiter state: rr_ptr (clog2(NUM_REQ) bits), burst_cnt (clog2(MAX_BURST)+1 bits), lock (1 bit), lock_id.
- Grant select (combinational): if lock and req_valid[lock_id], grant lock_id. Otherwise grant the first i with req_valid[i], searching from rr_ptr upward with wrap.
- fifo_wr_en = any grant & !fifo_full; req_ready[g] = fifo_wr_en; fifo_din = req_data of g; grant_id = g.
- On an accepted beat: burst_cnt+1. If burst_cnt+1 == MAX_BURST, or req_valid[g] will drop (beat accepted and requester deasserts next cycle — evaluated next cycle via the lock rule), clear lock, clear burst_cnt, and set rr_ptr = g+1 mod NUM_REQ. Otherwise set lock=1 and lock_id=g.
- Lock is released whenever req_valid[lock_id]=0. rr_ptr then advances to lock_id+1 and burst_cnt clears.
- fifo_full=1: no write and no state change. The grant may be shown but req_ready=0.
- Read side: buffer of 2 entries (occupancy 0–2), plus inflight register = fifo_rd_en from the previous cycle.
- fifo_rd_en = !fifo_empty & (occupancy + inflight − pop) < 2, where pop = out_valid & out_ready.
- When inflight=1, push fifo_dout into the buffer. out_valid = occupancy>0; out_data = buffer head.
- Simultaneous push and pop keeps occupancy unchanged, with order preserved.

## Timing
- Reset values: rr_ptr=0, burst_cnt=0, lock=0, inflight=0, occupancy=0, out_valid=0, req_ready=0, fifo_wr_en=0, fifo_rd_en=0, grant_id=0, out_data=0.
- Write path is combinational from req_valid/fifo_full to fifo_wr_en/req_ready, with 0-cycle latency. The data is written on the same edge.
- Read latency from a FIFO word becoming available (empty falls) to out_valid: 2 cycles (rd_en, then capture).
- Sustained throughput is 1 word/cycle both ways when out_ready=1.
- srst mid-transfer drops the in-flight read word and buffer contents. The FIFO itself is reset by the same srst.

## Structure
- Package fifo_ctrl_pkg holds DATA_W default, a clog2 function, and the localparam for the ID width.
- One sub-module, fifo_rd_prefetch, implements the 2-entry buffer, inflight and the rd_en logic. The arbiter stays in the top module.

## Test plan
- Reset, then all 4 requesters valid with MAX_BURST=1 and data 0x10+i: FIFO receives 0x10, 0x11, 0x12, 0x13, 0x10, … in grant order 0,1,2,3,0.
- MAX_BURST=4, requesters 1 and 2 always valid: grants are 1,1,1,1,2,2,2,2,1. req_ready is never asserted on two bits at once.
- fifo_full=1 for 3 cycles during a burst: no writes, burst_cnt is held, and the burst resumes on the same requester when full drops.
- FIFO preloaded with 0xA0..0xA4, out_ready=1: out_data is 0xA0..0xA4 on consecutive cycles, with the first out_valid 2 cycles after empty=0.
- out_ready toggling 1,0,0,1 with a non-empty FIFO: no word lost or duplicated, occupancy never exceeds 2, and rd_en is suppressed when the buffer plus inflight count equals 2.
- srst asserted while the buffer holds 2 words: the next cycle has out_valid=0, fifo_rd_en=0, all req_ready=0 and rr_ptr=0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the FIFO port controller.
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int NUM_REQ_DEF = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int ID_W_DEF = clog2(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_rd_prefetch.sv
// Two-entry prefetch buffer that turns the FIFO read port into a valid/ready stream.
module fifo_rd_prefetch
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic [DATA_W-1:0] buf_q [2];
    logic              head_q;
    logic [1:0]        occ_q;
    logic              inflight_q;
    logic              pop;
    logic              wr_idx;
    logic [2:0]        level;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_q[head_q];
    assign pop       = out_valid && out_ready;

    // Words already held or on their way, after this cycle's pop.
    assign level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = !srst && !fifo_empty && (level < 3'd2);

    // A push only happens with occupancy <= 1, so the tail is head or head^1.
    assign wr_idx = head_q ^ occ_q[0];

    always_ff @(posedge clk) begin
        if (srst) begin
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (srst) begin
                buf_q[gi] <= '0;
            end else if (inflight_q && (wr_idx == 1'(gi))) begin
                buf_q[gi] <= fifo_dout;
            end
        end
    end

endmodule

// File: rtl/fifo_port_controller.sv
// Shares one FIFO between NUM_REQ writers (round-robin with burst hold) and
// exposes its read port as a registered valid/ready stream.
module fifo_port_controller
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    output logic                      fifo_rd_en,
    input  logic [DATA_W-1:0]         fifo_dout,
    input  logic                      fifo_empty,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready
);

    localparam int ID_W = clog2(NUM_REQ);
    localparam int BC_W = clog2(MAX_BURST) + 1;

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    logic [ID_W-1:0] grant;
    logic            grant_any;
    logic            lock_hold;
    logic            lock_drop;
    logic [ID_W-1:0] search_start;
    logic [BC_W-1:0] burst_inc;
    int              idx;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        lock_hold    = lock_q && req_valid[lock_id_q];
        lock_drop    = lock_q && !req_valid[lock_id_q];
        // A lock that just dropped hands priority to the requester after it.
        search_start = lock_drop ? next_id(lock_id_q) : rr_ptr_q;
        grant        = search_start;
        grant_any    = 1'b0;
        idx          = 0;
        if (lock_hold) begin
            grant     = lock_id_q;
            grant_any = 1'b1;
        end else begin
            // Descending scan so the nearest requester after search_start wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(search_start) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (req_valid[idx]) begin
                    grant     = ID_W'(idx);
                    grant_any = 1'b1;
                end
            end
        end
    end

    assign fifo_wr_en = grant_any && !fifo_full && !srst;
    assign fifo_din   = req_data[int'(grant)*DATA_W +: DATA_W];
    assign grant_id   = srst ? '0 : grant;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = fifo_wr_en && (grant == ID_W'(gi));
    end

    assign burst_inc = (lock_drop ? '0 : burst_cnt_q) + 1'b1;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
        if (fifo_wr_en) begin
            if (burst_inc == BC_W'(MAX_BURST)) begin
                lock_d      = 1'b0;
                burst_cnt_d = '0;
                rr_ptr_d    = next_id(grant);
            end else begin
                lock_d      = 1'b1;
                lock_id_d   = grant;
                burst_cnt_d = burst_inc;
            end
        end else if (!fifo_full && lock_drop) begin
            lock_d      = 1'b0;
            burst_cnt_d = '0;
            rr_ptr_d    = next_id(lock_id_q);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
        end
    end

    fifo_rd_prefetch #(
        .DATA_W(DATA_W)
    ) u_rd_prefetch (
        .clk        (clk),
        .srst       (srst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

endmodule

// File: tb/tb_fifo_port_controller.sv
// Directed bench: arbitration order, burst hold, full stall, read prefetch and reset.
module tb_fifo_port_controller;

    logic        clk = 1'b0;
    logic        srst;

    // Main instance (MAX_BURST=4) with a behavioural FIFO attached.
    logic [3:0]  rv;
    logic [31:0] rdata;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    // Pure round-robin instance (MAX_BURST=1), write side only.
    logic [3:0]  b1_rv;
    logic [3:0]  b1_req_ready;
    logic [1:0]  b1_grant_id;
    logic [7:0]  b1_fifo_din;
    logic        b1_fifo_wr_en;
    logic        b1_fifo_rd_en;
    logic        b1_out_valid;
    logic [7:0]  b1_out_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fifo_port_controller #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .srst(srst), .req_valid(rv), .req_data(rdata),
        .req_ready(req_ready), .grant_id(grant_id), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    fifo_port_controller #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .srst(srst), .req_valid(b1_rv), .req_data(32'h13121110),
        .req_ready(b1_req_ready), .grant_id(b1_grant_id), .fifo_din(b1_fifo_din),
        .fifo_wr_en(b1_fifo_wr_en), .fifo_full(1'b0), .fifo_rd_en(b1_fifo_rd_en),
        .fifo_dout(8'h00), .fifo_empty(1'b1), .out_valid(b1_out_valid),
        .out_data(b1_out_data), .out_ready(1'b0)
    );

    // Behavioural 16-deep FIFO; the bench can also write it directly.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    logic       full_force;
    logic       tb_wr;
    logic [7:0] tb_din;
    logic       m_wr, m_rd;
    logic [7:0] m_din;

    assign fifo_full  = full_force || (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);
    assign m_wr       = tb_wr || (fifo_wr_en && !fifo_full);
    assign m_din      = tb_wr ? tb_din : fifo_din;
    assign m_rd       = fifo_rd_en && (cnt != 5'd0);

    always @(posedge clk) begin
        if (srst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            fifo_dout <= '0;
        end else begin
            if (m_wr) begin
                mem[wp] <= m_din;
                wp      <= wp + 4'd1;
            end
            if (m_rd) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 4'd1;
            end
            cnt <= cnt + {4'b0, m_wr} - {4'b0, m_rd};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("  ok %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    initial begin
        int exp_g2 [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        int full3  [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        int wr3    [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int g3     [8] = '{1, 1, 1, 1, 1, 1, 1, 2};
        int rdy4   [4] = '{1, 0, 0, 1};
        int g;
        int pops;

        srst       = 1'b1;
        rv         = 4'b0;
        rdata      = 32'h23222120;
        out_ready  = 1'b0;
        b1_rv      = 4'b0;
        full_force = 1'b0;
        tb_wr      = 1'b0;
        tb_din     = 8'h00;
        do_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_out_data", 32'(out_data), 0);

        // Pure round-robin across four requesters.
        b1_rv = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            g = i % 4;
            chk($sformatf("rr_grant[%0d]", i), 32'(b1_grant_id), 32'(g));
            chk($sformatf("rr_din[%0d]", i), 32'(b1_fifo_din), 32'(8'h10 + g));
            chk($sformatf("rr_ready[%0d]", i), 32'(b1_req_ready), 32'(1 << g));
            tick();
        end
        b1_rv = 4'b0;

        // Burst hold of four beats between requesters 1 and 2.
        do_reset();
        rv = 4'b0110;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("burst_grant[%0d]", i), 32'(grant_id), 32'(exp_g2[i]));
            chk($sformatf("burst_din[%0d]", i), 32'(fifo_din), 32'(8'h20 + exp_g2[i]));
            chk($sformatf("burst_ready[%0d]", i), 32'(req_ready), 32'(1 << exp_g2[i]));
            tick();
        end
        rv = 4'b0;

        // FIFO full for three cycles in the middle of a burst.
        do_reset();
        rv = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            full_force = (full3[i] != 0);
            #1;
            chk($sformatf("full_wr_en[%0d]", i), 32'(fifo_wr_en), 32'(wr3[i]));
            chk($sformatf("full_grant[%0d]", i), 32'(grant_id), 32'(g3[i]));
            chk($sformatf("full_ready[%0d]", i), 32'(req_ready),
                wr3[i] != 0 ? 32'(1 << g3[i]) : 32'd0);
            tick();
        end
        full_force = 1'b0;
        rv = 4'b0;

        // Streaming read with out_ready held high.
        do_reset();
        out_ready = 1'b1;
        tb_wr     = 1'b1;
        tb_din    = 8'hA0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j + 1 < 5) tb_din = 8'(8'hA0 + j + 1);
            else           tb_wr  = 1'b0;
            #1;
            if (j == 0) chk("stream_rd_en_first", 32'(fifo_rd_en), 1);
            chk($sformatf("stream_valid[%0d]", j), 32'(out_valid), (j >= 2 && j <= 6) ? 32'd1 : 32'd0);
            if (j >= 2 && j <= 6) begin
                chk($sformatf("stream_data[%0d]", j), 32'(out_data), 32'(8'hA0 + j - 2));
            end
        end

        // Back-pressure: buffer fills, rd_en stops, then ready toggles 1,0,0,1.
        do_reset();
        out_ready = 1'b0;
        tb_wr     = 1'b1;
        tb_din    = 8'hC0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j + 1 < 4) tb_din = 8'(8'hC0 + j + 1);
            else           tb_wr  = 1'b0;
            #1;
            chk($sformatf("bp_rd_en[%0d]", j), 32'(fifo_rd_en), (j < 2) ? 32'd1 : 32'd0);
        end
        pops = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            out_ready = (rdy4[t % 4] != 0);
            #1;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_pop[%0d]", pops), 32'(out_data), 32'(8'hC0 + pops));
                pops++;
            end
        end
        chk("bp_pop_count", 32'(pops), 4);
        chk("bp_drained", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Reset while the buffer is full and rr_ptr has moved.
        do_reset();
        rdata = 32'h23222120;
        rv    = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("pre_rst_grant[%0d]", i), 32'(grant_id), 1);
            tick();
        end
        rv = 4'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        chk("pre_rst_out_data", 32'(out_data), 32'h21);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_rd_en", 32'(fifo_rd_en), 0);
        chk("post_rst_req_ready", 32'(req_ready), 0);
        rv = 4'b1010;
        #1;
        chk("post_rst_rr_ptr_grant", 32'(grant_id), 1);
        rv = 4'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
